// File: rtl/a2_datapath_pkg.sv
// Shared datapath constants and types for the write-back, register file and decode stages.
package a2_datapath_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_data_t REG_RESET_VAL = 8'h00;

endpackage

// File: rtl/a2_reg8.sv
// Single DATA_W storage register with write enable and asynchronous active-high clear.
module a2_reg8 #(
    parameter int unsigned        DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/a2_register_file.sv
// Eight-entry register file: one synchronous write port, two combinational read ports.
// Defining REGFILE_BYPASS_EN forwards a same-cycle write to a matching read port.
module a2_register_file #(
    parameter int unsigned NUM_REGS = a2_datapath_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = a2_datapath_pkg::ADDR_W,
    parameter int unsigned DATA_W   = a2_datapath_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WriteReg,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] result,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import a2_datapath_pkg::*;

    localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(REG_RESET_VAL);

    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    always_comb begin
        wr_en = '0;
        if (WriteReg) begin
            wr_en[rd] = 1'b1;
        end
    end

    // Writes presented while reset is high are dropped because clr dominates en.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        a2_reg8 #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RST_VAL)
        ) u_reg (
            .clk (clk),
            .clr (reset),
            .en  (wr_en[i]),
            .d   (result),
            .q   (regs[i])
        );
    end

    always_comb begin
        read_data1 = regs[rs1];
        read_data2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (WriteReg && (rs1 == rd)) begin
            read_data1 = result;
        end
        if (WriteReg && (rs2 == rd)) begin
            read_data2 = result;
        end
`endif
        if (reset) begin
            read_data1 = RST_VAL;
            read_data2 = RST_VAL;
        end
    end

endmodule
